// File: rtl/sd_modulator.sv
// Second-order sigma-delta modulator with a sample FIFO, driving a 1-bit DSD stream
// and its companion clock SDCLK_O. DSD_O updates on the SDCLK_O falling-edge cycle.
`timescale 1ns/1ps
module sd_modulator #(
  parameter int DW         = 16,
  parameter int ACC_W      = 20,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             EXTCLK,
  input  logic             EXTRSTn,
  input  logic             EN,
  input  logic [DIV_W-1:0] CLKDIV,
  input  logic [7:0]       SAMPLE_DIV,
  input  logic             S_VALID,
  input  logic [DW-1:0]    S_DATA,
  output logic             S_READY,
  output logic [LW-1:0]    FIFO_LEVEL,
  input  logic             CLR_UF,
  output logic             UNDERFLOW,
  output logic             SDCLK_O,
  output logic             DSD_O
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_W+1:0] FS   = (ACC_W+2)'(1 << (DW-1));
  localparam logic signed [ACC_W+1:0] AMAX = (ACC_W+2)'((1 << (ACC_W-1)) - 1);
  localparam logic signed [ACC_W+1:0] AMIN = (ACC_W+2)'(-(1 << (ACC_W-1)));

  logic [DW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level;
  logic [DIV_W-1:0]        cnt;
  logic [7:0]              bcnt;
  logic signed [ACC_W-1:0] i1, i2, i1n, i2n;
  logic signed [DW-1:0]    x_reg, x_eff;
  logic signed [ACC_W+1:0] fb, s1, s2;
  logic                    push, pop, tog, u_evt, uf_set;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W+1:0] v);
    if (v > AMAX)      return AMAX[ACC_W-1:0];
    else if (v < AMIN) return AMIN[ACC_W-1:0];
    else               return v[ACC_W-1:0];
  endfunction

  assign S_READY    = (level < LW'(FIFO_DEPTH));
  assign FIFO_LEVEL = level;
  assign push       = S_VALID && S_READY;

  // U: the cycle in which SDCLK_O goes 1->0; every modulator state change is tied to it
  assign tog    = EN && (cnt >= CLKDIV);
  assign u_evt  = tog && SDCLK_O;
  assign pop    = u_evt && (bcnt == 8'd0) && (level != '0);
  assign uf_set = u_evt && (bcnt == 8'd0) && (level == '0);
  assign x_eff  = pop ? $signed(mem[rd_ptr]) : x_reg;

  always_comb begin
    fb  = DSD_O ? FS : -FS;
    s1  = {{2{i1[ACC_W-1]}}, i1} + {{(ACC_W+2-DW){x_eff[DW-1]}}, x_eff} - fb;
    i1n = sat(s1);
    s2  = {{2{i2[ACC_W-1]}}, i2} + {{2{i1n[ACC_W-1]}}, i1n} - fb;
    i2n = sat(s2);
  end

  always_ff @(posedge EXTCLK) begin
    if (push) mem[wr_ptr] <= S_DATA;
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      cnt <= '0; bcnt <= '0; SDCLK_O <= 1'b0; DSD_O <= 1'b0;
      i1 <= '0; i2 <= '0; x_reg <= '0;
    end else if (!EN) begin
      cnt <= '0; bcnt <= '0; SDCLK_O <= 1'b0; DSD_O <= 1'b0;
      i1 <= '0; i2 <= '0; x_reg <= '0;
    end else begin
      if (tog) begin
        cnt     <= '0;
        SDCLK_O <= ~SDCLK_O;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (u_evt) begin
        x_reg <= x_eff;
        bcnt  <= (bcnt >= SAMPLE_DIV) ? 8'd0 : bcnt + 8'd1;
        i1    <= i1n;
        i2    <= i2n;
        DSD_O <= ~i2n[ACC_W-1];
      end
    end
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn)    UNDERFLOW <= 1'b0;
    else if (uf_set) UNDERFLOW <= 1'b1;
    else if (CLR_UF) UNDERFLOW <= 1'b0;
  end
endmodule
